// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_detect_pkg;

    localparam int unsigned PATTERN_W_MIN = 2;
    localparam int unsigned PATTERN_W_MAX = 16;

    // Detection modes as stored in the overlap register.
    localparam logic MODE_NONOVLP = 1'b0;
    localparam logic MODE_OVLP    = 1'b1;

    // Working width of sat_inc; counters up to this width are supported.
    localparam int unsigned SAT_W = 32;

    // Increment val by one, holding at max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        return (val == max_val) ? val : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and registered all-ones flag.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);
    import seq_detect_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // Clear beats increment; the flag tracks the value being written.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = CNT_W'(sat_inc(SAT_W'(cnt_q), SAT_W'(CNT_MAX)));
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    // Counter and flag registers, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial detector for a runtime-programmable pattern with overlap control and match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned          PATTERN_W   = 4,
    parameter int unsigned          MATCH_CNT_W = 8,
    parameter logic [PATTERN_W-1:0] RST_PATTERN = PATTERN_W'(4'b1010)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d,
    input  logic                   d_valid,
    input  logic                   cfg_load,
    input  logic [PATTERN_W-1:0]   cfg_pattern,
    input  logic                   cfg_overlap,
    input  logic                   cnt_clr,
    output logic                   q,
    output logic [MATCH_CNT_W-1:0] match_cnt,
    output logic                   cnt_sat
);

    localparam int unsigned          FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(PATTERN_W);

    if (PATTERN_W < PATTERN_W_MIN || PATTERN_W > PATTERN_W_MAX) begin : g_bad_width
        $error("seq_detect_param: PATTERN_W out of range");
    end

    logic [PATTERN_W-1:0] hist_q, hist_d, hist_nxt;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_nxt;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic                 overlap_q, overlap_d;
    logic                 q_q, q_d;
    logic                 hit_c;

    // Shift history / fill tracking, configuration load and match decision.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        q_d       = 1'b0;
        hit_c     = 1'b0;
        hist_nxt  = {hist_q[PATTERN_W-2:0], d};
        fill_nxt  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

        if (cfg_load) begin
            // d is dropped on a load edge; the stream restarts from an empty window.
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
            fill_d    = '0;
        end else if (d_valid) begin
            hit_c  = (hist_nxt == pattern_q) && (fill_nxt == FILL_FULL);
            hist_d = hist_nxt;
            fill_d = (hit_c && (overlap_q == MODE_NONOVLP)) ? '0 : fill_nxt;
            q_d    = hit_c;
        end
    end

    // Detector state registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= RST_PATTERN;
            overlap_q <= MODE_NONOVLP;
            q_q       <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            q_q       <= q_d;
        end
    end

    sat_counter #(
        .CNT_W (MATCH_CNT_W)
    ) u_match_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (cnt_clr),
        .inc_i  (hit_c),
        .cnt_o  (match_cnt),
        .sat_o  (cnt_sat)
    );

    assign q = q_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param; driver queues expected outputs, monitor checks them.
module tb_seq_detect_param;

    logic       clk;
    logic       reset;
    logic       d;
    logic       d_valid;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       q;
    logic [1:0] match_cnt;
    logic       cnt_sat;

    typedef struct {
        logic       q;
        logic [1:0] cnt;
        logic       sat;
        int         idx;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    seq_detect_param #(
        .PATTERN_W   (4),
        .MATCH_CNT_W (2),
        .RST_PATTERN (4'b1010)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d           (d),
        .d_valid     (d_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .q           (q),
        .match_cnt   (match_cnt),
        .cnt_sat     (cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare outputs against the queued expectation for each clock.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.q) begin
                errors++;
                $display("FAIL q step=%0d got=%b exp=%b", e.idx, q, e.q);
            end
            checks++;
            if (match_cnt !== e.cnt) begin
                errors++;
                $display("FAIL match_cnt step=%0d got=%0d exp=%0d", e.idx, match_cnt, e.cnt);
            end
            checks++;
            if (cnt_sat !== e.sat) begin
                errors++;
                $display("FAIL cnt_sat step=%0d got=%b exp=%b", e.idx, cnt_sat, e.sat);
            end
        end
    end

    // Drive one clock of inputs and queue the outputs expected after that edge.
    task automatic step(input logic r, input logic dv, input logic dd, input logic ld,
                        input logic clr, input logic [3:0] pat, input logic ov,
                        input logic eq, input logic [1:0] ec, input logic es);
        reset       = r;
        d_valid     = dv;
        d           = dd;
        cfg_load    = ld;
        cnt_clr     = clr;
        cfg_pattern = pat;
        cfg_overlap = ov;
        @(posedge clk);
        #1;
        sb.push_back(exp_t'{q: eq, cnt: ec, sat: es, idx: step_no});
        step_no++;
    endtask

    task automatic bitv(input logic dd, input logic eq, input logic [1:0] ec, input logic es);
        step(1'b1, 1'b1, dd, 1'b0, 1'b0, 4'b0000, 1'b0, eq, ec, es);
    endtask

    task automatic idle(input logic [1:0] ec, input logic es);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, ec, es);
    endtask

    task automatic load(input logic [3:0] pat, input logic ov, input logic clr,
                        input logic [1:0] ec);
        step(1'b1, 1'b1, 1'b0, 1'b1, clr, pat, ov, 1'b0, ec, 1'b0);
    endtask

    initial begin
        reset = 1'b0; d = 1'b0; d_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 4'b0000; cfg_overlap = 1'b0; cnt_clr = 1'b0;

        // Reset with noisy inputs: reset must win.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // Default pattern 1010, non-overlap: 10101010 -> hits after bits 4 and 8.
        bitv(1, 0, 2'd0, 0); bitv(0, 0, 2'd0, 0); bitv(1, 0, 2'd0, 0); bitv(0, 1, 2'd1, 0);
        bitv(1, 0, 2'd1, 0); bitv(0, 0, 2'd1, 0); bitv(1, 0, 2'd1, 0); bitv(0, 1, 2'd2, 0);
        idle(2'd2, 0);

        // Overlap mode: 101010 -> hits after bits 4 and 6.
        load(4'b1010, 1'b1, 1'b1, 2'd0);
        bitv(1, 0, 2'd0, 0); bitv(0, 0, 2'd0, 0); bitv(1, 0, 2'd0, 0); bitv(0, 1, 2'd1, 0);
        bitv(1, 0, 2'd1, 0); bitv(0, 1, 2'd2, 0);
        idle(2'd2, 0);

        // Same stream, non-overlap: single hit after bit 4.
        load(4'b1010, 1'b0, 1'b1, 2'd0);
        bitv(1, 0, 2'd0, 0); bitv(0, 0, 2'd0, 0); bitv(1, 0, 2'd0, 0); bitv(0, 1, 2'd1, 0);
        bitv(1, 0, 2'd1, 0); bitv(0, 0, 2'd1, 0);
        idle(2'd1, 0);

        // Stalled stream: one single-cycle pulse, none during stalls.
        load(4'b1010, 1'b0, 1'b1, 2'd0);
        bitv(1, 0, 2'd0, 0); idle(2'd0, 0); idle(2'd0, 0); idle(2'd0, 0);
        bitv(0, 0, 2'd0, 0); idle(2'd0, 0); idle(2'd0, 0); idle(2'd0, 0);
        bitv(1, 0, 2'd0, 0); idle(2'd0, 0); idle(2'd0, 0); idle(2'd0, 0);
        bitv(0, 1, 2'd1, 0); idle(2'd1, 0); idle(2'd1, 0); idle(2'd1, 0);

        // Reset mid-pattern: 1,0,1, reset, 0 must not match; next 1010 does.
        bitv(1, 0, 2'd1, 0); bitv(0, 0, 2'd1, 0); bitv(1, 0, 2'd1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        bitv(0, 0, 2'd0, 0);
        bitv(1, 0, 2'd0, 0); bitv(0, 0, 2'd0, 0); bitv(1, 0, 2'd0, 0); bitv(0, 1, 2'd1, 0);

        // Saturation of the 2-bit counter: 1,2,3,3,3 with sat from the 3rd match.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int m = 0; m < 5; m++) begin
            logic [1:0] c;
            logic       s;
            c = (m >= 2) ? 2'd3 : 2'(m + 1);
            s = (m >= 2);
            bitv(1, 0, (m == 0) ? 2'd0 : ((m >= 3) ? 2'd3 : 2'(m)), (m >= 3));
            bitv(0, 0, (m == 0) ? 2'd0 : ((m >= 3) ? 2'd3 : 2'(m)), (m >= 3));
            bitv(1, 0, (m == 0) ? 2'd0 : ((m >= 3) ? 2'd3 : 2'(m)), (m >= 3));
            bitv(0, 1, c, s);
        end
        // Sixth match with clear on the same edge: clear wins, q still pulses.
        bitv(1, 0, 2'd3, 1); bitv(0, 0, 2'd3, 1); bitv(1, 0, 2'd3, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
        idle(2'd0, 0);

        // Bits accepted before a load never contribute to a match.
        bitv(1, 0, 2'd0, 0); bitv(1, 0, 2'd0, 0);
        load(4'b1100, 1'b0, 1'b0, 2'd0);
        bitv(0, 0, 2'd0, 0); bitv(0, 0, 2'd0, 0); bitv(1, 0, 2'd0, 0);
        bitv(1, 0, 2'd0, 0); bitv(0, 0, 2'd0, 0); bitv(0, 1, 2'd1, 0);
        idle(2'd1, 0);

        // Let the monitor drain the scoreboard, bounded.
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised successor to the fixed-pattern serial sequence detectors in the FSM library.
- Watches a 1-bit serial stream and flags each occurrence of a runtime-programmable PATTERN_W-bit pattern.
- Overlapping or non-overlapping detection is selected at configuration time.
- Keeps a saturating match count; sits between a serial front-end and a status/interrupt block.

Parameters:
- PATTERN_W, 4, pattern length in bits (legal 2..16).
- MATCH_CNT_W, 8, width of the saturating match counter.
- RST_PATTERN, 4'b1010 (PATTERN_W bits), pattern value loaded at reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- d  input  1  serial data bit.
- d_valid  input  1  d is sampled only when 1.
- cfg_load  input  1  loads cfg_pattern/cfg_overlap on this edge.
- cfg_pattern  input  PATTERN_W  new pattern; bit [PATTERN_W-1] is the first bit received.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- q  output  1  registered one-cycle match pulse.
- match_cnt  output  MATCH_CNT_W  number of matches since reset/clear, saturating.
- cnt_sat  output  1  high while match_cnt is all-ones.
- cnt_clr  input  1  synchronous clear of match_cnt/cnt_sat.

Behaviour:
- Reset (reset==0 at a rising edge):
  - hist=0, fill=0, q=0, match_cnt=0, cnt_sat=0.
  - pattern=RST_PATTERN, overlap=0.
  - Reset overrides every other input.
- State:
  - hist[PATTERN_W-1:0] holds the last accepted bits.
  - fill is 0..PATTERN_W, the count of valid bits since the last restart; it saturates at PATTERN_W.
- Accepted bit (d_valid=1, cfg_load=0):
  - hist_next={hist[PATTERN_W-2:0],d}; fill_next=min(fill+1,PATTERN_W).
  - hit = (hist_next==pattern) && (fill_next==PATTERN_W).
  - On hit:
    - q<=1 on this edge, so q is high in the cycle after the final pattern bit is sampled (Moore-style, latency 1).
    - Non-overlap: fill<=0, so the next match needs PATTERN_W fresh bits.
    - Overlap: fill stays PATTERN_W, so the shared suffix/prefix counts.
- d_valid=0: hist/fill hold and q<=0. The q pulse is exactly one cycle even if the stream stalls.
- cfg_load=1:
  - pattern<=cfg_pattern, overlap<=cfg_overlap, fill<=0, q<=0.
  - d is ignored on that edge even if d_valid=1.
- Counter:
  - On hit, match_cnt increments unless it is all-ones (no wrap).
  - cnt_sat is registered and equals (match_cnt==all-ones).
  - cnt_clr=1 zeroes match_cnt and cnt_sat. If a hit occurs on the same edge, clear wins, count=0, and q still pulses.
- Self-overlapping patterns (e.g. 1111, 1010):
  - Behaviour is defined purely by the fill/hist rule above; no prefix-table FSM.
- Patterns whose length is less than PATTERN_W are not supported; the full width is always compared.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package seq_detect_pkg:
  - localparam bounds PATTERN_W_MIN=2, PATTERN_W_MAX=16.
  - Function for saturating increment.
  - Mode constant names MODE_NONOVLP=0, MODE_OVLP=1.
- One sub-module, sat_counter, holding the MATCH_CNT_W saturating counter with clear and sat flag.
- The history/fill logic stays in seq_detect_param.

Test Plan:
- Reset defaults (pattern 1010, non-overlap); stream 1,0,1,0,1,0,1,0 with d_valid=1 -> q pulses after bit 4 and after bit 8; match_cnt=2.
- cfg_load pattern=1010, overlap=1; stream 1,0,1,0,1,0 -> q pulses after bits 4 and 6; match_cnt=2. The same stream with overlap=0 -> a single pulse after bit 4.
- Stream 1,0,1,0 with d_valid low for 3 cycles between each bit -> exactly one q pulse, one cycle long, the cycle after the edge sampling the last 0; no re-pulse during stalls.
- Stream 1,0,1, then reset=0 for one cycle, then 0 -> no q pulse; match_cnt=0; the next full 1,0,1,0 matches normally.
- MATCH_CNT_W=2, non-overlap; 5 x "1010" -> match_cnt sequence 1,2,3,3,3; cnt_sat=1 after the 3rd match. cnt_clr asserted together with the 6th match -> match_cnt=0, q=1.
- After 1,1 are accepted, cfg_load pattern=1100; then stream 0,0,1,1,0,0 -> no match from the pre-load bits; one pulse after the final 0; match_cnt=1.
